regfile_rd_seq: RTL and testbench
=================================

// Module: regfile_rd_seq
// PURPOSE
//  Read-side sequencer for the single-read-port 32x32 distributed-RAM register file.
//  Accepts one request carrying two source addresses (rs1, rs2), reads them one after
//  the other through the RAM's asynchronous read port, and returns both operands together.
//  Snoops the RAM write port so returned operands always reflect the newest write.
//  Sits between the CPU decode stage and the regfile; the writer drives the RAM directly.
// PARAMETERS
//  ADDR_WIDTH  5   register address width (32 entries)
//  DATA_WIDTH  32  register data width
//  ZERO_REG    1   1: address 0 always reads 0 and is never forwarded; 0: entry 0 is ordinary
// PORTS
//  clk        in   1           sole clock; regfile write clock is the same net
//  rst        in   1           asynchronous reset, active-high
//  req_valid  in   1           request present
//  req_ready  out  1           request accepted on clk edge when req_valid & req_ready
//  rs1_addr   in   ADDR_WIDTH  first source register, sampled at acceptance
//  rs2_addr   in   ADDR_WIDTH  second source register, sampled at acceptance
//  rsp_valid  out  1           operands valid
//  rsp_ready  in   1           consumer takes response on edge when rsp_valid & rsp_ready
//  rs1_data   out  DATA_WIDTH  operand 1
//  rs2_data   out  DATA_WIDTH  operand 2
//  rf_raddr   out  ADDR_WIDTH  to regfile read address
//  rf_rdata   in   DATA_WIDTH  from regfile read data (combinational from rf_raddr)
//  wr_en      in   1           snoop: regfile write enable (write commits on this clk edge)
//  wr_addr    in   ADDR_WIDTH  snoop: regfile write address
//  wr_data    in   DATA_WIDTH  snoop: regfile write data
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1, rsp_valid=0, rs1_data=rs2_data=0, rf_raddr=0, addr regs 0.
//  FSM (registered state; all outputs decoded from registers, no input->output comb path
//   except none; rf_raddr is a registered-state decode):
//   IDLE: req_ready=1, rf_raddr=0. On req_valid: latch rs1_q/rs2_q -> RD1.
//   RD1 : req_ready=0, rf_raddr=rs1_q. Edge: rs1_data<=sel(rs1_q) -> RD2.
//   RD2 : rf_raddr=rs2_q. Edge: rs2_data<=sel(rs2_q) -> RESP.
//   RESP: rsp_valid=1, rf_raddr=0. On rsp_ready -> IDLE (rsp_valid drops next cycle).
//  sel(a): 0 if ZERO_REG && a==0; else wr_data if wr_en && wr_addr==a; else rf_rdata.
//   (RAM read is pre-write in the writing cycle, so a same-cycle write must be forwarded.)
//  Hold coherency: in RD2 and RESP, wr_en hit on rs1_q (not zero reg) updates rs1_data
//   with wr_data; in RESP, hit on rs2_q updates rs2_data. Same edge as the hit; if
//   rsp_ready is also high that edge, the consumer sees the pre-update value (defined).
//  Latency: accept at edge N -> rsp_valid high from cycle after edge N+2; min 4 cycles
//   per request (no back-to-back accept from RESP). rs1_addr==rs2_addr is legal; both
//   reads still performed, identical data returned.
//  req_valid while req_ready=0 ignored (requester must hold). rsp_valid held with stable
//   data (except snoop updates) until rsp_ready.
//  rst mid-operation: immediate return to IDLE, in-flight request dropped, no response.
//  Width: addresses compared full ADDR_WIDTH; no arithmetic.
// TESTING
//  1 Reg5=0xDEADBEEF, reg9=0x12345678; req rs1=5 rs2=9 -> 3 edges later rsp 0xDEADBEEF/0x12345678.
//  2 req rs1=0 rs2=0 with reg0 written 0xFFFFFFFF (ZERO_REG=1) -> both operands 0.
//  3 Write reg7=0xA5A5A5A5 in RD1 cycle of req rs1=7 -> rs1_data=0xA5A5A5A5 (forwarded).
//  4 Hold rsp_ready=0 for 5 cycles, write reg9=0x1 in RESP -> rs2_data becomes 0x1; rs1 unchanged.
//  5 Assert rst in RD2 -> next cycle req_ready=1, rsp_valid=0, data 0; no response emitted.
//  6 Random back-to-back requests vs. reference model, random rsp_ready stalls -> zero mismatches.

Source files
------------

// File: rtl/regfile_rd_seq_if.sv
// Request/response handshake between the decode stage (master) and the
// register-file read sequencer (slave).
interface regfile_rd_seq_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    modport master (
        output req_valid, rs1_addr, rs2_addr, rsp_ready,
        input  req_ready, rsp_valid, rs1_data, rs2_data
    );

    modport slave (
        input  req_valid, rs1_addr, rs2_addr, rsp_ready,
        output req_ready, rsp_valid, rs1_data, rs2_data
    );
endinterface

// File: rtl/regfile_rd_seq.sv
// Read-side sequencer for a single-read-port register file. Reads rs1 then
// rs2 through the asynchronous RAM port and returns both operands together,
// snooping the write port so the held operands always track the newest write.
//
// state | meaning
// IDLE  | ready for a request, read port parked at 0
// RD1   | read port on rs1, capture rs1 operand at edge
// RD2   | read port on rs2, capture rs2 operand at edge
// RESP  | operands valid, waiting for consumer
module regfile_rd_seq #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_rd_seq_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;

    logic                  zero1, zero2;
    logic                  hit1, hit2;
    logic [DATA_WIDTH-1:0] sel1, sel2;

    // Operand select: zero register, then same-cycle write forward (the RAM
    // read is pre-write in the writing cycle), then the RAM read data.
    always_comb begin
        zero1 = (ZERO_REG != 0) && (rs1_q == '0);
        zero2 = (ZERO_REG != 0) && (rs2_q == '0);
        hit1  = wr_en && (wr_addr == rs1_q) && !zero1;
        hit2  = wr_en && (wr_addr == rs2_q) && !zero2;
        sel1  = zero1 ? '0 : (hit1 ? wr_data : rf_rdata);
        sel2  = zero2 ? '0 : (hit2 ? wr_data : rf_rdata);
    end

    // Sequencer FSM with all outputs registered; rf_raddr is loaded one
    // state ahead so it presents the address of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rf_raddr      <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rs1_data  <= '0;
            bus.rs2_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rs1_q         <= bus.rs1_addr;
                        rs2_q         <= bus.rs2_addr;
                        rf_raddr      <= bus.rs1_addr;
                        bus.req_ready <= 1'b0;
                        state         <= RD1;
                    end
                end
                RD1: begin
                    bus.rs1_data <= sel1;
                    rf_raddr     <= rs2_q;
                    state        <= RD2;
                end
                RD2: begin
                    bus.rs2_data <= sel2;
                    if (hit1) bus.rs1_data <= wr_data;
                    rf_raddr      <= '0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    // Snoop updates still apply on the handshake edge; the
                    // consumer has already taken the pre-update value.
                    if (hit1) bus.rs1_data <= wr_data;
                    if (hit2) bus.rs2_data <= wr_data;
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    rf_raddr      <= '0;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_rd_seq.sv
// Bench for regfile_rd_seq: a 32x32 RAM with asynchronous read, directed
// vector table, multi-cycle corner sequences and a randomised stall run.
module tb_regfile_rd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    regfile_rd_seq_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    regfile_rd_seq #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    // Register-file RAM: synchronous write, asynchronous read.
    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
    assign rf_rdata = mem[rf_raddr];

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Present a request at a negedge; returns at the negedge of the RD1 cycle.
    task automatic issue(input logic [4:0] a1, input logic [4:0] a2);
        chk("req_ready_before_issue", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.rs1_addr = a1; bus.rs2_addr = a2;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_take", {31'd0, bus.rsp_valid}, 32'd0);
        chk("req_ready_after_take", {31'd0, bus.req_ready}, 32'd1);
    endtask

    function automatic logic [31:0] model(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem[a];
    endfunction

    logic [9:0] q [$];
    logic       pending;
    logic       rr;
    logic [9:0] head;
    int         accepted;
    bit         saw_rsp;

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus.req_valid = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rs1_data", bus.rs1_data, 32'd0);
        chk("reset_rs2_data", bus.rs2_data, 32'd0);
        chk("reset_rf_raddr", {27'd0, rf_raddr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 32; i++) write_reg(i[4:0], 32'h100 + i);
        write_reg(5'd0,  32'hFFFF_FFFF);
        write_reg(5'd5,  32'hDEAD_BEEF);
        write_reg(5'd9,  32'h1234_5678);
        write_reg(5'd3,  32'h3333_3333);
        write_reg(5'd31, 32'hF1F1_F1F1);

        vecs[0] = '{5'd5,  5'd9,  32'hDEAD_BEEF, 32'h1234_5678};
        vecs[1] = '{5'd9,  5'd5,  32'h1234_5678, 32'hDEAD_BEEF};
        vecs[2] = '{5'd0,  5'd0,  32'h0,         32'h0};
        vecs[3] = '{5'd3,  5'd3,  32'h3333_3333, 32'h3333_3333};
        vecs[4] = '{5'd31, 5'd0,  32'hF1F1_F1F1, 32'h0};
        vecs[5] = '{5'd0,  5'd31, 32'h0,         32'hF1F1_F1F1};
        vecs[6] = '{5'd1,  5'd30, 32'h0000_0101, 32'h0000_011E};

        // Directed table: also checks the read address sequence and latency.
        for (int v = 0; v < 7; v++) begin
            issue(vecs[v].rs1, vecs[v].rs2);
            chk($sformatf("v%0d_raddr_rd1", v), {27'd0, rf_raddr}, {27'd0, vecs[v].rs1});
            chk($sformatf("v%0d_rsp_valid_rd1", v), {31'd0, bus.rsp_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_raddr_rd2", v), {27'd0, rf_raddr}, {27'd0, vecs[v].rs2});
            chk($sformatf("v%0d_rsp_valid_rd2", v), {31'd0, bus.rsp_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_rsp_valid", v), {31'd0, bus.rsp_valid}, 32'd1);
            chk($sformatf("v%0d_req_ready_resp", v), {31'd0, bus.req_ready}, 32'd0);
            chk($sformatf("v%0d_raddr_resp", v), {27'd0, rf_raddr}, 32'd0);
            chk($sformatf("v%0d_rs1_data", v), bus.rs1_data, vecs[v].exp1);
            chk($sformatf("v%0d_rs2_data", v), bus.rs2_data, vecs[v].exp2);
            take_rsp();
        end

        // Zero register is never forwarded, even on same-cycle writes.
        issue(5'd0, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        chk("zero_rs1_fwd", bus.rs1_data, 32'd0);
        chk("zero_rs2_fwd", bus.rs2_data, 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        chk("zero_rs1_hold", bus.rs1_data, 32'd0);
        chk("zero_rs2_hold", bus.rs2_data, 32'd0);
        take_rsp();

        // Same-cycle write forwarding in RD1 (rs1) and RD2 (rs2).
        issue(5'd7, 5'd5);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        wr_addr = 5'd5; wr_data = 32'h5555_AAAA;
        @(negedge clk);
        wr_en = 1'b0;
        chk("fwd_rd1_rs1", bus.rs1_data, 32'hA5A5_A5A5);
        chk("fwd_rd2_rs2", bus.rs2_data, 32'h5555_AAAA);
        take_rsp();

        // Stalled response with a snoop hit on rs2 partway through.
        issue(5'd5, 5'd9);
        @(negedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0001; end
            else wr_en = 1'b0;
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("stall_rs1_unchanged", bus.rs1_data, 32'h5555_AAAA);
        chk("stall_rs2_snooped", bus.rs2_data, 32'h0000_0001);
        take_rsp();

        // Snoop hit on rs1 while in RD2.
        issue(5'd3, 5'd31);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0BAD_F00D;
        @(negedge clk);
        wr_en = 1'b0;
        chk("rd2_rs1_snooped", bus.rs1_data, 32'h0BAD_F00D);
        chk("rd2_rs2", bus.rs2_data, 32'hF1F1_F1F1);
        take_rsp();

        // Reset in RD2 drops the request without a response.
        issue(5'd5, 5'd9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_rs1_data", bus.rs1_data, 32'd0);
        chk("rst_mid_rs2_data", bus.rs2_data, 32'd0);
        rst = 1'b0;
        saw_rsp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        chk("rst_mid_no_rsp", {31'd0, saw_rsp}, 32'd0);

        // Random requests, writes and stalls; every response cycle must show
        // the newest register contents for the queued request.
        pending = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            rr = ($urandom_range(0, 2) != 0);
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
                end else begin
                    head = q[0];
                    chk("rand_rs1", bus.rs1_data, model(head[9:5]));
                    chk("rand_rs2", bus.rs2_data, model(head[4:0]));
                    if (rr) void'(q.pop_front());
                end
            end
            bus.rsp_ready = rr;
            if (!pending && ($urandom_range(0, 1) != 0)) begin
                pending = 1'b1;
                bus.rs1_addr = 5'($urandom_range(0, 7));
                bus.rs2_addr = 5'($urandom_range(0, 7));
            end
            bus.req_valid = pending;
            if (pending && bus.req_ready) begin
                q.push_back({bus.rs1_addr, bus.rs2_addr});
                accepted++;
                pending = 1'b0;
            end
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 5'($urandom_range(0, 7));
            wr_data = $urandom;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        wr_en = 1'b0;
        for (int d = 0; d < 20 && q.size() != 0; d++) begin
            if (bus.rsp_valid) begin
                head = q[0];
                chk("drain_rs1", bus.rs1_data, model(head[9:5]));
                chk("drain_rs2", bus.rs2_data, model(head[4:0]));
                void'(q.pop_front());
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        chk("rand_all_responded", q.size(), 32'd0);
        chk("rand_some_accepted", {31'd0, (accepted > 100)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
